// File: rtl/mult_iter_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier with
// mod-3 residue checking.
package mult_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Residue mod 3 of up to 64 bits: each 2-bit pair has weight 4^k == 1 (mod 3),
  // so the pairs are summed with a running reduction.
  function automatic logic [1:0] mod3(input logic [63:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r = r + {1'b0, v[2*i +: 2]};
      if (r >= 3'd3) r = r - 3'd3;
    end
    return r[1:0];
  endfunction

  // Counter widths: CNT_W = clog2(WIDTH), RTY_W = clog2(RETRY+1), never below 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_unsigned_iter_mod3_residue.sv
// Combinational mod-3 residue of a W-bit unsigned vector (W <= 64).
module mod3_residue
  import mult_iter_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] v,
  output logic [1:0]   r
);

  logic [63:0] ext;

  always_comb begin
    ext        = '0;
    ext[W-1:0] = v;
    r          = mod3(ext);
  end

endmodule

// File: rtl/mult_unsigned_iter.sv
// Iterative WIDTHxWIDTH unsigned multiplier: one shift-add step per cycle,
// mod-3 residue check on the result with up to RETRY automatic recomputes.
module mult_unsigned_iter
  import mult_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RETRY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               fault,
  output logic               busy,
  input  logic               flt_inj
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = clog2_min1(WIDTH);
  localparam int unsigned RTY_W = clog2_min1(RETRY + 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [PW-1:0]      acc, addend, acc_upd;
  logic [CNT_W-1:0]   cnt;
  logic [RTY_W-1:0]   rty;
  logic [1:0]         ra, rb, ra_in, rb_in, racc, rexp;
  logic               fault_q, last_bit, chk_ok;

  mod3_residue #(.W(WIDTH)) u_res_a   (.v(a),   .r(ra_in));
  mod3_residue #(.W(WIDTH)) u_res_b   (.v(b),   .r(rb_in));
  mod3_residue #(.W(PW))    u_res_acc (.v(acc), .r(racc));

  always_comb begin
    addend     = b_q[cnt] ? (PW'(a_q) << cnt) : '0;
    acc_upd    = acc + addend;
    // Fault hook flips bit 0 after this cycle's add has been applied.
    acc_upd[0] = acc_upd[0] ^ flt_inj;
    last_bit   = (cnt == CNT_W'(WIDTH - 1));
    rexp       = mod3(64'({2'b00, ra} * {2'b00, rb}));
    chk_ok     = (rexp == racc);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    if (last_bit) state_nx = CHECK;
      CHECK:   if (chk_ok || rty == '0) state_nx = DONE;
               else                     state_nx = CALC;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ra      <= '0;
      rb      <= '0;
      acc     <= '0;
      cnt     <= '0;
      rty     <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          ra  <= ra_in;
          rb  <= rb_in;
          acc <= '0;
          cnt <= '0;
          rty <= RTY_W'(RETRY);
        end
        CALC: begin
          acc <= acc_upd;
          cnt <= last_bit ? '0 : cnt + 1'b1;
        end
        CHECK: begin
          if (chk_ok) begin
            fault_q <= 1'b0;
          end else if (rty != '0) begin
            rty <= rty - 1'b1;
            acc <= '0;
            cnt <= '0;
          end else begin
            fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = acc;
  assign fault     = fault_q;

endmodule
